// File: rtl/coded_mask_pkg.sv
// Shared types, constants and helpers for the coded-exposure mask generator.
package coded_mask_pkg;

   typedef enum logic [1:0] {
      REPEAT = 2'b00,
      SLIDE  = 2'b01,
      RANDOM = 2'b10,
      RSVD   = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      FILL = 2'b01,
      RUN  = 2'b10
   } state_t;

   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

   // Number of active columns for a given resolution code.
   function automatic int unsigned active_cols(input logic [1:0] res, input int unsigned max_cols);
      return max_cols >> res;
   endfunction

endpackage

// File: rtl/coded_mask_gen_lfsr.sv
// 32-bit right-shifting Galois LFSR; out_bit is the bit shifted out on a step.
module mask_lfsr
   import coded_mask_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] seed,
   input  logic        load,
   input  logic        step,
   output logic        out_bit
);

   logic [31:0] lfsr_q;
   logic [31:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (load) begin
         // An all-zero state would lock up, so it is replaced by 1.
         lfsr_d = (seed == 32'd0) ? 32'd1 : seed;
      end else if (step) begin
         lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : 32'd0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= 32'd1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign out_bit = lfsr_q[0];

endmodule

// File: rtl/coded_mask_gen.sv
// Row-mask generator for the coded-exposure pixel array (repeat / slide / random).
// Random mode and its LFSR exist only when RANDOM_MASK_EN is defined.
module coded_mask_gen
   import coded_mask_pkg::*;
#(
   parameter int MAX_COLS = 64,
   parameter int PAT_MAX  = 32,
   parameter int ROW_W    = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clk_en,
   input  logic [1:0]                 cfg_res,
   input  logic [1:0]                 cfg_mode,
   input  logic [0:PAT_MAX-1]         cfg_pattern,
   input  logic [$clog2(PAT_MAX):0]   cfg_pattern_w,
   input  logic                       cfg_dir,
   input  logic [ROW_W-1:0]           cfg_rows,
   input  logic                       load,
   input  logic                       mask_ready,
   output logic                       mask_valid,
   output logic [0:MAX_COLS-1]        mask,
   output logic [ROW_W-1:0]           mask_row,
   output logic                       mask_last,
   output logic                       busy
);

   localparam int CI = $clog2(MAX_COLS);
   localparam int PI = $clog2(PAT_MAX);
   localparam logic [PI:0] W_MAX = (PI+1)'(PAT_MAX);

   state_t              state_q, state_d;
   mode_t               mode_q, mode_d;
   logic                dir_q, dir_d;
   logic [CI:0]         a_q, a_d;
   logic [PI:0]         w_q, w_d;
   logic [ROW_W-1:0]    rows_q, rows_d;
   logic [0:PAT_MAX-1]  pat_q, pat_d;
   logic [CI-1:0]       col_q, col_d;
   logic [PI-1:0]       pidx_q, pidx_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic                valid_q, valid_d;
   logic                last_q, last_d;
   logic [0:MAX_COLS-1] mask_q, mask_d;

   logic [CI-1:0]       last_col;
   logic [PI-1:0]       w_last;
   logic                fill_bit;
   logic [0:MAX_COLS-1] rot_r, rot_l;

   assign last_col = CI'(a_q - 1'b1);
   assign w_last   = PI'(w_q - 1'b1);

`ifdef RANDOM_MASK_EN
   logic lfsr_bit;

   mask_lfsr u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .seed    (32'(cfg_pattern)),
      .load    (clk_en & load),
      .step    (clk_en & ~load & (state_q == FILL) & (mode_q == RANDOM)),
      .out_bit (lfsr_bit)
   );

   assign fill_bit = (mode_q == RANDOM) ? lfsr_bit : pat_q[pidx_q];
`else
   assign fill_bit = pat_q[pidx_q];
`endif

   // Rotation by one position confined to the active columns; inactive columns stay 0.
   for (genvar gi = 0; gi < MAX_COLS; gi++) begin : g_rot
      localparam int PREV = (gi + MAX_COLS - 1) % MAX_COLS;
      localparam int NEXT = (gi + 1) % MAX_COLS;
      logic in_range;
      logic at_last;
      assign in_range  = ((CI+1)'(gi) < a_q);
      assign at_last   = (CI'(gi) == last_col);
      assign rot_r[gi] = in_range & ((gi == 0) ? mask_q[last_col] : mask_q[PREV]);
      assign rot_l[gi] = in_range & (at_last ? mask_q[0] : mask_q[NEXT]);
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      dir_d   = dir_q;
      a_d     = a_q;
      w_d     = w_q;
      rows_d  = rows_q;
      pat_d   = pat_q;
      col_d   = col_q;
      pidx_d  = pidx_q;
      row_d   = row_q;
      valid_d = valid_q;
      last_d  = last_q;
      mask_d  = mask_q;

      if (clk_en) begin
         if (load) begin
            unique case (cfg_mode)
               2'b01:   mode_d = SLIDE;
`ifdef RANDOM_MASK_EN
               2'b10:   mode_d = RANDOM;
`endif
               default: mode_d = REPEAT;
            endcase
            dir_d   = cfg_dir;
            a_d     = (CI+1)'(active_cols(cfg_res, MAX_COLS));
            if (cfg_pattern_w == '0) begin
               w_d = (PI+1)'(1);
            end else if (cfg_pattern_w > W_MAX) begin
               w_d = W_MAX;
            end else begin
               w_d = cfg_pattern_w;
            end
            rows_d  = (cfg_rows == '0) ? ROW_W'(1) : cfg_rows;
            pat_d   = cfg_pattern;
            col_d   = '0;
            pidx_d  = '0;
            row_d   = '0;
            valid_d = 1'b0;
            last_d  = (rows_d == ROW_W'(1));
            mask_d  = '0;
            state_d = FILL;
         end else begin
            unique case (state_q)
               FILL: begin
                  mask_d[col_q] = fill_bit;
                  pidx_d = (pidx_q == w_last) ? '0 : pidx_q + 1'b1;
                  col_d  = col_q + 1'b1;
                  if (col_q == last_col) begin
                     col_d   = '0;
                     valid_d = 1'b1;
                     state_d = RUN;
                  end
               end
               RUN: begin
                  if (valid_q && mask_ready) begin
                     if (last_q) begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                     end else begin
                        row_d  = row_q + ROW_W'(1);
                        last_d = (row_d == rows_q - ROW_W'(1));
                        unique case (mode_q)
                           SLIDE: mask_d = dir_q ? rot_r : rot_l;
`ifdef RANDOM_MASK_EN
                           RANDOM: begin
                              // Next row is drawn fresh; LFSR carries on without reseed.
                              valid_d = 1'b0;
                              col_d   = '0;
                              pidx_d  = '0;
                              state_d = FILL;
                           end
`endif
                           default: ;
                        endcase
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= REPEAT;
         dir_q   <= 1'b0;
         a_q     <= (CI+1)'(MAX_COLS);
         w_q     <= (PI+1)'(1);
         rows_q  <= ROW_W'(1);
         pat_q   <= '0;
         col_q   <= '0;
         pidx_q  <= '0;
         row_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         dir_q   <= dir_d;
         a_q     <= a_d;
         w_q     <= w_d;
         rows_q  <= rows_d;
         pat_q   <= pat_d;
         col_q   <= col_d;
         pidx_q  <= pidx_d;
         row_q   <= row_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         mask_q  <= mask_d;
      end
   end

   assign mask_valid = valid_q;
   assign mask       = mask_q;
   assign mask_row   = row_q;
   assign mask_last  = last_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_coded_mask_gen.sv
// Randomised self-checking bench for coded_mask_gen against a column/row-level mask model.
module tb_coded_mask_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        clk_en;
   logic [1:0]  cfg_res;
   logic [1:0]  cfg_mode;
   logic [0:31] cfg_pattern;
   logic [5:0]  cfg_pattern_w;
   logic        cfg_dir;
   logic [15:0] cfg_rows;
   logic        load;
   logic        mask_ready;
   logic        mask_valid;
   logic [0:63] mask;
   logic [15:0] mask_row;
   logic        mask_last;
   logic        busy;

   coded_mask_gen dut (
      .clk           (clk),
      .rst           (rst),
      .clk_en        (clk_en),
      .cfg_res       (cfg_res),
      .cfg_mode      (cfg_mode),
      .cfg_pattern   (cfg_pattern),
      .cfg_pattern_w (cfg_pattern_w),
      .cfg_dir       (cfg_dir),
      .cfg_rows      (cfg_rows),
      .load          (load),
      .mask_ready    (mask_ready),
      .mask_valid    (mask_valid),
      .mask          (mask),
      .mask_row      (mask_row),
      .mask_last     (mask_last),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Model state for the current frame.
   int          m_a, m_w, m_r;
   bit          m_rand, m_slide, m_dir;
   logic [0:31] m_pat;
   logic [31:0] m_lfsr;
   logic [63:0] exp_rows [16];
   logic [63:0] obs [16];
   logic [63:0] obs0 [16];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
      n_cmp++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, expv);
      end
   endtask

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return (s >> 1) ^ ({32{s[0]}} & 32'h8020_0003);
   endfunction

   task automatic set_cfg(input int res, input int mode, input logic [31:0] pat,
                          input int w, input int dir, input int rows);
      logic [0:63] bits;
      int src;
      cfg_res       = res[1:0];
      cfg_mode      = mode[1:0];
      cfg_pattern   = pat;
      cfg_pattern_w = w[5:0];
      cfg_dir       = dir[0];
      cfg_rows      = rows[15:0];
      m_a     = 64 >> res;
      m_w     = (w == 0) ? 1 : ((w > 32) ? 32 : w);
      m_r     = (rows == 0) ? 1 : rows;
      m_slide = (mode == 1);
      m_rand  = 1'b0;
`ifdef RANDOM_MASK_EN
      m_rand  = (mode == 2);
`endif
      m_dir   = dir[0];
      m_pat   = pat;
      m_lfsr  = (pat == 32'd0) ? 32'd1 : pat;
      for (int r = 0; r < m_r; r++) begin
         bits = '0;
         for (int c = 0; c < m_a; c++) begin
            if (m_rand) begin
               bits[c] = m_lfsr[0];
               m_lfsr  = lfsr_next(m_lfsr);
            end else begin
               if (!m_slide)   src = c;
               else if (m_dir) src = ((c - r) % m_a + m_a) % m_a;
               else            src = (c + r) % m_a;
               bits[c] = m_pat[src % m_w];
            end
         end
         exp_rows[r] = bits;
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!mask_valid && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      if (!mask_valid) chk("valid timeout", mask_valid, 1);
   endtask

   task automatic check_row(input int r);
      chk($sformatf("valid r%0d", r), mask_valid, 1);
      chk($sformatf("mask r%0d", r), mask, exp_rows[r]);
      chk($sformatf("row r%0d", r), mask_row, r);
      chk($sformatf("last r%0d", r), mask_last, (r == m_r - 1));
   endtask

   task automatic start_frame(input int res, input int mode, input logic [31:0] pat,
                              input int w, input int dir, input int rows);
      int n;
      set_cfg(res, mode, pat, w, dir, rows);
      load = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
      wait_valid(n);
      chk("latency", n + 1, m_a + 1);
   endtask

   // stall < 0 picks a random stall length per row.
   task automatic run_rows(input int stall, input int first);
      int n;
      int ns;
      for (int r = first; r < m_r; r++) begin
         if (r > first) begin
            wait_valid(n);
            chk("gap", n, m_rand ? m_a : 0);
         end
         check_row(r);
         obs[r] = mask;
         ns = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
         if (ns > 0) begin
            mask_ready = 1'b0;
            repeat (ns) begin
               @(posedge clk); #1;
               check_row(r);
            end
         end
         mask_ready = 1'b1;
         @(posedge clk); #1;
         $display("row %0d accepted mask=%h last=%0d stall=%0d", r, obs[r], (r == m_r - 1), ns);
      end
      chk("end valid", mask_valid, 0);
      chk("end busy", busy, 0);
   endtask

   initial begin
      int n;
      rst = 1'b1; clk_en = 1'b1; load = 1'b0; mask_ready = 1'b1;
      cfg_res = '0; cfg_mode = '0; cfg_pattern = '0; cfg_pattern_w = '0;
      cfg_dir = 1'b0; cfg_rows = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst valid", mask_valid, 0);
      chk("rst mask", mask, 0);
      chk("rst row", mask_row, 0);
      chk("rst last", mask_last, 0);
      chk("rst busy", busy, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Repeat, full resolution
      start_frame(0, 0, 32'hF000_0000, 8, 0, 3);
      run_rows(0, 0);
      chk("rep row0", obs[0], 64'hF0F0_F0F0_F0F0_F0F0);
      chk("rep row2", obs[2], 64'hF0F0_F0F0_F0F0_F0F0);

      // Slide right and left
      start_frame(0, 1, 32'hF000_0000, 8, 1, 9);
      run_rows(0, 0);
      chk("slide r row1", obs[1], 64'h7878_7878_7878_7878);
      chk("slide r row8", obs[8], 64'hF0F0_F0F0_F0F0_F0F0);
      start_frame(0, 1, 32'hF000_0000, 8, 0, 9);
      run_rows(0, 0);
      chk("slide l row1", obs[1], 64'hE1E1_E1E1_E1E1_E1E1);

      // Half resolution
      start_frame(1, 0, 32'hF000_0000, 8, 0, 3);
      run_rows(0, 0);
      chk("res1 row0", obs[0], 64'hF0F0_F0F0_0000_0000);
      start_frame(1, 1, 32'hF000_0000, 8, 1, 9);
      run_rows(-1, 0);
      chk("res1 wrap row1", obs[1], 64'h7878_7878_0000_0000);

      // Long back-pressure
      start_frame(0, 1, 32'h9C00_0000, 7, 0, 6);
      run_rows(5, 0);

      // Enable gap during FILL
      set_cfg(0, 0, 32'h1234_5678, 12, 0, 2);
      load = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      clk_en = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      clk_en = 1'b1;
      wait_valid(n);
      chk("clk_en latency", 14 + n, m_a + 4);
      run_rows(-1, 0);

      // Random mode
      start_frame(0, 2, 32'hAAAA_AAAA, 32, 0, 4);
      run_rows(0, 0);
      start_frame(0, 2, 32'h0000_0000, 32, 0, 2);
      run_rows(0, 0);
      obs0[0] = obs[0];
      obs0[1] = obs[1];
      start_frame(0, 2, 32'h0000_0001, 32, 0, 2);
      run_rows(-1, 0);
`ifdef RANDOM_MASK_EN
      chk("seed0 row0", obs0[0], obs[0]);
      chk("seed0 row1", obs0[1], obs[1]);
`endif

      // Abort at row 2 of 5, load beats simultaneous handshake
      start_frame(0, 0, 32'hCAFE_0000, 16, 0, 5);
      for (int r = 0; r < 3; r++) begin
         if (r > 0) begin
            wait_valid(n);
            chk("abort gap", n, 0);
         end
         check_row(r);
         if (r < 2) begin
            mask_ready = 1'b1;
            @(posedge clk); #1;
         end
      end
      mask_ready = 1'b1;
      set_cfg(1, 1, 32'h0F0F_1234, 12, 1, 3);
      load = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
      chk("abort valid", mask_valid, 0);
      chk("abort row", mask_row, 0);
      wait_valid(n);
      chk("abort latency", n + 1, m_a + 1);
      run_rows(0, 0);

      // Randomised configurations
      for (int i = 0; i < 10; i++) begin
         start_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
                     int'($urandom_range(0, 63)), int'($urandom_range(0, 1)),
                     int'($urandom_range(0, 6)));
         run_rows(-1, 0);
      end

      // Asynchronous reset mid-RUN
      start_frame(0, 1, $urandom, 20, 1, 6);
      mask_ready = 1'b1;
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("arst valid", mask_valid, 0);
      chk("arst mask", mask, 0);
      chk("arst row", mask_row, 0);
      chk("arst last", mask_last, 0);
      chk("arst busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post rst busy", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/coded_mask_gen.md
# coded_mask_gen

Parametrised successor mask generator for the coded-exposure pixel array: produces one MAX_COLS-bit pixel mask per sensor row, in repeated, sliding or pseudo-random mode. Adds a per-frame row count, a ready/valid output handshake with back-pressure, and a row index with end-of-frame marking. It sits between the micro-processor configuration registers and the row driver.

## Interface
- MAX_COLS, 64: maximum sensor columns; mask width. Must be a power of two, ≥ 8.
- PAT_MAX, 32: maximum pattern length in bits.
- ROW_W, 16: width of the row counter and the row count.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- clk_en  in  1  global enable. When low, all state freezes.
- cfg_res  in  2  resolution. Active columns A = MAX_COLS >> cfg_res.
- cfg_mode  in  2  mode: 00 repeat, 01 slide, 10 random, 11 reserved (treated as repeat).
- cfg_pattern  in  [0:PAT_MAX-1]  pattern bits. Index 0 maps to column 0. Also the LFSR seed (low 32 bits).
- cfg_pattern_w  in  $clog2(PAT_MAX)+1  pattern length W. A value of 0 is treated as 1; values above PAT_MAX are clamped to PAT_MAX.
- cfg_dir  in  1  slide direction: 1 right, 0 left.
- cfg_rows  in  ROW_W  rows per frame R. A value of 0 is treated as 1.
- load  in  1  latch all cfg_* inputs and start a frame.
- mask_ready  in  1  downstream accepts the current mask.
- mask_valid  out  1  mask, mask_row and mask_last are valid.
- mask  out  [0:MAX_COLS-1]  row mask. Columns ≥ A are always 0.
- mask_row  out  ROW_W  row index within the frame, 0..R-1.
- mask_last  out  1  high when mask_row == R-1.
- busy  out  1  frame in progress (any state other than IDLE).

## Operation
- FSM states: IDLE, FILL, RUN.
- IDLE, load=1 → FILL:
  - Configuration is latched.
  - Column counter, row counter and mask are cleared.
  - LFSR is seeded. A seed of 0 is replaced by 1.
- FILL: one column is written per enabled cycle, columns 0..A-1.
  - Repeat and slide modes: bit c = pattern[c mod W]. Implemented with a pattern-index counter that wraps at W; no divider.
  - Random mode: bit c = LFSR output bit.
  - After column A-1 is written → RUN, with mask_valid=1.
- LFSR: 32-bit Galois, right-shifting, feedback mask 32'h8020_0003. The output bit is lfsr[0] before the shift. It advances only while a random-mode FILL is writing.
- RUN, handshake (mask_valid & mask_ready):
  - If mask_last is set → IDLE, mask_valid=0.
  - Otherwise mask_row increments, then by mode:
    - Repeat: mask is held. mask_valid stays high with zero bubble.
    - Slide: mask is rotated by one position within columns 0..A-1, with zero bubble. Right: new[c] = old[(c-1) mod A]. Left: new[c] = old[(c+1) mod A].
    - Random: mask_valid drops and the FSM returns to FILL. The LFSR continues from its state; it is not reseeded.
- Back-pressure: while mask_valid=1 and mask_ready=0, mask, mask_row and mask_last hold stable.
- load in FILL or RUN aborts the current frame and restarts as from IDLE. load has priority over a simultaneous handshake.
- cfg_* changes without load have no effect.

## Timing
- Reset values: mask_valid=0, mask=0, mask_row=0, mask_last=0, busy=0, FSM=IDLE, LFSR=1. Outputs clear immediately on rst assertion.
- load is sampled at edge k. FILL runs on edges k+1..k+A, and mask_valid is high after edge k+A. First-row latency is therefore A+1 cycles.
- Repeat/slide throughput: one row per cycle while mask_ready=1.
- Random mode: A+1 cycles per row when the row is accepted immediately.
- Cycles with clk_en=0 extend every latency by one and do not count.
- All outputs are registered.

## Configuration
- RANDOM_MASK_EN defined: random mode and the LFSR are compiled in.
- RANDOM_MASK_EN undefined: no LFSR is instantiated, and cfg_mode 10 behaves as repeat.

## Structure
- Package coded_mask_pkg holds:
  - mode_t enum (REPEAT, SLIDE, RANDOM, RSVD).
  - state_t enum (IDLE, FILL, RUN).
  - LFSR_POLY = 32'h8020_0003.
  - Function active_cols(res, max_cols).
- Sub-module mask_lfsr is the 32-bit Galois LFSR, with ports seed, load, step and out_bit. It is instantiated only under RANDOM_MASK_EN.

## Test plan
- Repeat: MAX_COLS=64, res=00, pattern=32'hF000_0000, W=8, R=3, ready=1. Required: mask_valid rises 65 cycles after load; mask=64'hF0F0_F0F0_F0F0_F0F0 for rows 0,1,2; mask_last on row 2; then IDLE.
- Slide: same pattern, W=8, R=9.
  - dir=1: row1 = 64'h7878_…_78, row8 = 64'hF0F0_…_F0.
  - dir=0: row1 = 64'hE1E1_…_E1.
  - Zero bubble between rows in both directions.
- Resolution: res=01, repeat, same pattern. Required: mask=64'hF0F0_F0F0_0000_0000, valid 33 cycles after load. Slide right with res=01 wraps at column 31 (bit 31 → bit 0); columns 32..63 stay 0.
- Back-pressure and enable: hold mask_ready=0 for 5 cycles mid-frame. Required: mask, mask_row and mask_valid stable. clk_en=0 for 3 cycles during FILL delays mask_valid by exactly 3 cycles.
- Random: seed 32'hAAAA_AAAA, R=4, compared bit-exact against a behavioural LFSR model; each row is 65 cycles. Seed 0 must produce the sequence of seed 1.
- Abort and reset:
  - load at row 2 of 5 → the first new mask has mask_row=0 and follows the new configuration.
  - Asynchronous rst mid-RUN → all outputs zero before the next edge.
